matrix_reader: RTL

- Streams an n x n matrix of 32-bit elements out of a synchronous-read RAM, one element per transfer, on a value_stb/value_ack handshake.
- It is the source end of the same element interface the result writer consumes, and it feeds operands to the multiplier datapath.
- Supports row-major order and column-major (transposed) traversal, so matrix B can be delivered column-wise.
- Reports the (i, j) index of the presented element and pulses done after the last one.

---
 rtl/matrix_pkg.sv | 18 +
 rtl/index_counter_2d.sv | 53 +++++
 rtl/matrix_reader.sv | 112 +++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix element reader: FSM encodings,
// traversal order constants and the default element width.
package matrix_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD    = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic ORDER_ROW = 1'b0;
    localparam logic ORDER_COL = 1'b1;

    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/index_counter_2d.sv
// Two-dimensional (i, j) index counter for an n x n matrix. Row order
// steps j fastest, column order steps i fastest. Wrap points compare
// against n-1 so non-power-of-two dimensions count correctly.
module index_counter_2d
    import matrix_pkg::*;
#(
    parameter  int n  = 8,
    localparam int IW = $clog2(n)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    input  logic          order,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic          last
);

    localparam logic [IW-1:0] IMAX = IW'(n - 1);

    logic i_wrap;
    logic j_wrap;

    assign i_wrap = (i == IMAX);
    assign j_wrap = (j == IMAX);
    assign last   = i_wrap && j_wrap;

    // Step the index pair in the selected traversal order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            i <= '0;
            j <= '0;
        end else if (advance) begin
            if (order == ORDER_ROW) begin
                if (j_wrap) begin
                    j <= '0;
                    i <= i_wrap ? '0 : i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end else begin
                if (i_wrap) begin
                    i <= '0;
                    j <= j_wrap ? '0 : j + 1'b1;
                end else begin
                    i <= i + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/matrix_reader.sv
// Streams an n x n matrix out of a synchronous-read RAM one element per
// value_stb/value_ack transfer, in row-major or column-major order.
// Storage is always row-major, so the RAM address is i*n + j.
module matrix_reader
    import matrix_pkg::*;
#(
    parameter  int n     = 8,
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IW    = $clog2(n),
    localparam int AW    = $clog2(n * n)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             col_major,
    output logic             mem_rd_en,
    output logic [AW-1:0]    mem_addr,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] value,
    output logic             value_stb,
    input  logic             value_ack,
    output logic [IW-1:0]    i,
    output logic [IW-1:0]    j,
    output logic             busy,
    output logic             done
);

    state_t state;
    logic   order;
    logic   clear;
    logic   advance;
    logic   last;
    logic   xfer;

    assign xfer    = (state == S_PRESENT) && value_ack;
    assign clear   = (state == S_IDLE) && start;
    // The final element keeps its indices; the next start clears them.
    assign advance = xfer && !last;

    // Indices only move on an accepted transfer, so i/j are stable while
    // an element waits for its ack.
    assign mem_addr = AW'(i) * AW'(n) + AW'(j);

    index_counter_2d #(
        .n (n)
    ) u_idx (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .advance (advance),
        .order   (order),
        .i       (i),
        .j       (j),
        .last    (last)
    );

    // Fetch / load / present sequencer with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            order     <= ORDER_ROW;
            value     <= '0;
            value_stb <= 1'b0;
            mem_rd_en <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        order     <= col_major;
                        state     <= S_FETCH;
                        mem_rd_en <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    value     <= mem_rdata;
                    value_stb <= 1'b1;
                    state     <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (value_ack) begin
                        value_stb <= 1'b0;
                        if (last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_FETCH;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    value_stb <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
